mem_access_ctrl: RTL and testbench



---
 rtl/mem_access_ctrl.sv | 153 +++++++++++++++
 tb/tb_mem_access_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: turns level-style control-unit memory requests into single-cycle strobes
// on a fixed-latency synchronous SRAM. Define MEM_ACCESS_STATS_EN for RD_COUNT/WR_COUNT outputs.
module mem_access_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 26,
  parameter int RD_LATENCY = 2,
  parameter int WR_LATENCY = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [ADDR_WIDTH-1:0] MEM_ADDR,
  input  logic                  MEM_READ,
  input  logic                  MEM_WRITE,
  inout  wire  [DATA_WIDTH-1:0] MEM_DATA,
  output logic                  MEM_READY,
  output logic [ADDR_WIDTH-1:0] SRAM_ADDR,
  output logic                  SRAM_CE,
  output logic                  SRAM_WE,
  output logic [DATA_WIDTH-1:0] SRAM_WDATA,
  input  logic [DATA_WIDTH-1:0] SRAM_RDATA
`ifdef MEM_ACCESS_STATS_EN
  ,
  output logic [15:0]           RD_COUNT,
  output logic [15:0]           WR_COUNT
`endif
);

  localparam int MAX_LAT = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE} state_t;

  state_t                  state_reg;
  logic [CNT_W-1:0]        cnt_reg;
  logic                    last_valid_reg;
  logic                    last_wr_reg;
  logic [ADDR_WIDTH-1:0]   last_addr_reg;
  logic [DATA_WIDTH-1:0]   last_wdata_reg;
  logic [DATA_WIDTH-1:0]   rd_hold_reg;
  logic                    rd_valid_reg;
  logic                    mem_ready_reg;
  logic                    sram_ce_reg;
  logic                    sram_we_reg;
  logic [ADDR_WIDTH-1:0]   sram_addr_reg;
  logic [DATA_WIDTH-1:0]   sram_wdata_reg;
`ifdef MEM_ACCESS_STATS_EN
  logic [15:0]             rd_count_reg;
  logic [15:0]             wr_count_reg;
`endif

  // Case equality so that X/Z on the request lines decodes as a no-op.
  logic req_rd;
  logic req_wr;
  logic req_valid;
  logic key_match;
  logic drive_rd;

  assign req_rd    = (MEM_READ === 1'b1) && (MEM_WRITE === 1'b0);
  assign req_wr    = (MEM_READ === 1'b0) && (MEM_WRITE === 1'b1);
  assign req_valid = req_rd || req_wr;
  assign key_match = last_valid_reg && (req_wr == last_wr_reg) && (MEM_ADDR == last_addr_reg) &&
                     (!req_wr || (MEM_DATA == last_wdata_reg));

  assign drive_rd  = req_rd && rd_valid_reg && (MEM_ADDR == last_addr_reg);
  assign MEM_DATA  = drive_rd ? rd_hold_reg : {DATA_WIDTH{1'bz}};

  assign MEM_READY  = mem_ready_reg;
  assign SRAM_ADDR  = sram_addr_reg;
  assign SRAM_CE    = sram_ce_reg;
  assign SRAM_WE    = sram_we_reg;
  assign SRAM_WDATA = sram_wdata_reg;
`ifdef MEM_ACCESS_STATS_EN
  assign RD_COUNT   = rd_count_reg;
  assign WR_COUNT   = wr_count_reg;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg      <= ST_IDLE;
      cnt_reg        <= '0;
      last_valid_reg <= 1'b0;
      last_wr_reg    <= 1'b0;
      last_addr_reg  <= '0;
      last_wdata_reg <= '0;
      rd_hold_reg    <= '0;
      rd_valid_reg   <= 1'b0;
      mem_ready_reg  <= 1'b0;
      sram_ce_reg    <= 1'b0;
      sram_we_reg    <= 1'b0;
      sram_addr_reg  <= '0;
      sram_wdata_reg <= '0;
`ifdef MEM_ACCESS_STATS_EN
      rd_count_reg   <= '0;
      wr_count_reg   <= '0;
`endif
    end else begin
      sram_ce_reg <= 1'b0;
      sram_we_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (req_valid && !key_match) begin
            last_valid_reg <= 1'b1;
            last_wr_reg    <= req_wr;
            last_addr_reg  <= MEM_ADDR;
            if (req_wr) last_wdata_reg <= MEM_DATA;
            rd_valid_reg   <= 1'b0;
            state_reg      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          sram_ce_reg   <= 1'b1;
          sram_we_reg   <= last_wr_reg;
          sram_addr_reg <= last_addr_reg;
          if (last_wr_reg) sram_wdata_reg <= last_wdata_reg;
          cnt_reg   <= last_wr_reg ? CNT_W'(WR_LATENCY) : CNT_W'(RD_LATENCY);
          state_reg <= ST_WAIT;
        end
        ST_WAIT: begin
          // cnt counts cycles remaining after the strobe edge; zero marks the data edge.
          if (cnt_reg == '0) begin
            if (!last_wr_reg) begin
              rd_hold_reg  <= SRAM_RDATA;
              rd_valid_reg <= 1'b1;
            end
            if (req_valid && key_match) begin
              mem_ready_reg <= 1'b1;
              state_reg     <= ST_DONE;
`ifdef MEM_ACCESS_STATS_EN
              if (!last_wr_reg && rd_count_reg != 16'hFFFF) rd_count_reg <= rd_count_reg + 16'd1;
              if (last_wr_reg && wr_count_reg != 16'hFFFF) wr_count_reg <= wr_count_reg + 16'd1;
`endif
            end else begin
              // Request withdrawn or changed: finish silently and re-arm for any new key.
              last_valid_reg <= 1'b0;
              state_reg      <= ST_IDLE;
            end
          end else begin
            cnt_reg <= cnt_reg - CNT_W'(1);
          end
        end
        ST_DONE: begin
          if (!(req_valid && key_match)) begin
            mem_ready_reg <= 1'b0;
            state_reg     <= ST_IDLE;
            if (!req_valid) last_valid_reg <= 1'b0;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: SRAM accesses and completions are checked against
// expectations queued when each request is driven.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [25:0] mem_addr;
  logic        mem_read;
  logic        mem_write;
  wire  [31:0] mem_data;
  logic        mem_ready;
  logic [25:0] sram_addr;
  logic        sram_ce;
  logic        sram_we;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;
`ifdef MEM_ACCESS_STATS_EN
  logic [15:0] rd_count;
  logic [15:0] wr_count;
`endif

  logic [31:0] tb_data;
  logic        tb_drive;
  logic [31:0] zw;
  assign mem_data = tb_drive ? tb_data : 32'bz;

  always #5 clk = ~clk;

  mem_access_ctrl dut (
    .CLK(clk), .RST(rst),
    .MEM_ADDR(mem_addr), .MEM_READ(mem_read), .MEM_WRITE(mem_write), .MEM_DATA(mem_data),
    .MEM_READY(mem_ready),
    .SRAM_ADDR(sram_addr), .SRAM_CE(sram_ce), .SRAM_WE(sram_we),
    .SRAM_WDATA(sram_wdata), .SRAM_RDATA(sram_rdata)
`ifdef MEM_ACCESS_STATS_EN
    , .RD_COUNT(rd_count), .WR_COUNT(wr_count)
`endif
  );

  // SRAM model: contents are a fixed function of address, read latency 2 from the CE cycle.
  function automatic logic [31:0] sram_val(input logic [25:0] a);
    return (a == 26'h10) ? 32'hDEADBEEF : ({6'h0, a} ^ 32'h5A5A_0000);
  endfunction

  logic [31:0] pipe0, pipe1;
  always @(posedge clk) begin
    pipe0 <= (sram_ce && !sram_we) ? sram_val(sram_addr) : 32'h0BAD0BAD;
    pipe1 <= pipe0;
  end
  assign sram_rdata = pipe1;

  typedef struct packed {logic we; logic [25:0] addr; logic [31:0] wdata;} acc_t;
  typedef struct packed {logic is_rd; logic [25:0] addr; logic [31:0] data;} done_t;
  acc_t  exp_acc_q[$];
  done_t exp_done_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int ce_count = 0;
  logic ready_prev = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Monitor: every strobe and every MEM_READY rise consumes one scoreboard entry.
  always @(negedge clk) begin
    acc_t  a;
    done_t d;
    if (sram_ce) begin
      ce_count <= ce_count + 1;
      if (exp_acc_q.size() == 0) check("ce_unexpected", 1, 0);
      else begin
        a = exp_acc_q.pop_front();
        check("ce_we", sram_we, a.we);
        check("ce_addr", sram_addr, a.addr);
        if (a.we) check("ce_wdata", sram_wdata, a.wdata);
      end
    end
    if (mem_ready && !ready_prev) begin
      if (exp_done_q.size() == 0) check("ready_unexpected", 1, 0);
      else begin
        d = exp_done_q.pop_front();
        check(d.is_rd ? "rd_data" : "wr_bus", mem_data, d.data);
        $display("[TB] %s addr=%h data=%h", d.is_rd ? "read " : "write", d.addr, mem_data);
      end
    end
    ready_prev <= mem_ready;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic wr, input logic rd, input logic [25:0] a, input logic [31:0] d);
    mem_write = wr;
    mem_read  = rd;
    mem_addr  = a;
    tb_data   = d;
    tb_drive  = wr;
  endtask

  task automatic expect_txn(input logic wr, input logic [25:0] a, input logic [31:0] d);
    acc_t  ae;
    done_t de;
    ae = '{we: wr, addr: a, wdata: d};
    de = '{is_rd: !wr, addr: a, data: wr ? d : sram_val(a)};
    exp_acc_q.push_back(ae);
    exp_done_q.push_back(de);
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (mem_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_ready"}, mem_ready, 1);
    @(negedge clk);
    #1;
  endtask

  initial begin
    int c0;
    zw  = 'z;
    rst = 1'b1;
    set_req(0, 0, 26'h0, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", mem_ready, 0);
    check("rst_ce", sram_ce, 0);
    check("rst_addr", sram_addr, 0);
    check("rst_bus_z", mem_data, zw);
    rst = 1'b0;
    tick();

    // Read with cycle-exact timing: CE only after edge 1, READY from edge 4.
    set_req(0, 1, 26'h10, 32'h0);
    expect_txn(0, 26'h10, 32'h0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("rd_ce_e%0d", i), sram_ce, (i == 1));
      check($sformatf("rd_ready_e%0d", i), mem_ready, (i >= 4));
    end
    check("rd_bus_held", mem_data, 32'hDEADBEEF);
    tick();
    tick();
    mem_read = 1'b0;
    #1;
    check("rd_bus_released", mem_data, zw);
    tick();
    tick();

    // Write at the top address: single CE+WE, READY from edge 3, bus never driven by DUT.
    set_req(1, 0, 26'h3FFFFFF, 32'h12345678);
    expect_txn(1, 26'h3FFFFFF, 32'h12345678);
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("wr_ce_e%0d", i), sram_ce, (i == 1));
      check($sformatf("wr_we_e%0d", i), sram_we, (i == 1));
      check($sformatf("wr_ready_e%0d", i), mem_ready, (i >= 3));
      check($sformatf("wr_bus_e%0d", i), mem_data, 32'h12345678);
    end
    set_req(0, 0, 26'h0, 32'h0);
    #1;
    check("wr_bus_released", mem_data, zw);
    tick();
    tick();

    // Asynchronous reset pulse while idle clears the registered SRAM side.
    #2 rst = 1'b1;
    #1;
    check("rst2_ready", mem_ready, 0);
    check("rst2_ce", sram_ce, 0);
    check("rst2_addr", sram_addr, 0);
    check("rst2_wdata", sram_wdata, 0);
    check("rst2_bus_z", mem_data, zw);
    tick();
    rst = 1'b0;
    tick();

    // Same read separated by one no-op cycle: two accesses.
    c0 = ce_count;
    set_req(0, 1, 26'h10, 32'h0);
    expect_txn(0, 26'h10, 32'h0);
    wait_ready("gap_a");
    set_req(0, 0, 26'h0, 32'h0);
    tick();
    set_req(0, 1, 26'h10, 32'h0);
    expect_txn(0, 26'h10, 32'h0);
    wait_ready("gap_b");
    check("gap_ce_count", ce_count - c0, 2);

    // Address change straight out of DONE: new strobe after DONE exits.
    c0 = ce_count;
    set_req(0, 1, 26'h11, 32'h0);
    expect_txn(0, 26'h11, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("nogap_ce_e%0d", i), sram_ce, (i == 2));
    end
    wait_ready("nogap");
    repeat (3) tick();
    check("repeat_no_access", ce_count - c0, 1);
    check("repeat_still_ready", mem_ready, 1);
    set_req(0, 0, 26'h0, 32'h0);
    tick();
    tick();

    // Reset one cycle after the strobe; held request restarts cleanly.
    set_req(0, 1, 26'h20, 32'h0);
    expect_txn(0, 26'h20, 32'h0);
    tick();
    tick();
    tick();
    rst = 1'b1;
    void'(exp_done_q.pop_back());
    #1;
    check("rstw_ready", mem_ready, 0);
    check("rstw_bus_z", mem_data, zw);
    tick();
    check("rstw_ready_held", mem_ready, 0);
    expect_txn(0, 26'h20, 32'h0);
    c0 = ce_count;
    rst = 1'b0;
    #1;
    check("rstw_bus_after", mem_data, zw);
    wait_ready("rstw_fresh");
    check("rstw_fresh_ce", ce_count - c0, 1);
    set_req(0, 0, 26'h0, 32'h0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    // Withdraw during WAIT: access completes, READY never rises.
    begin
      acc_t ae;
      ae = '{we: 1'b0, addr: 26'h30, wdata: 32'h0};
      exp_acc_q.push_back(ae);
    end
    set_req(0, 1, 26'h30, 32'h0);
    tick();
    tick();
    tick();
    set_req(0, 0, 26'h0, 32'h0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("wd_ready_%0d", i), mem_ready, 0);
    end
`ifdef MEM_ACCESS_STATS_EN
    check("wd_rd_count", rd_count, 0);
`endif
    set_req(0, 1, 26'h30, 32'h0);
    expect_txn(0, 26'h30, 32'h0);
    wait_ready("wd_again");
    set_req(0, 0, 26'h0, 32'h0);
    tick();
    set_req(0, 1, 26'h31, 32'h0);
    expect_txn(0, 26'h31, 32'h0);
    wait_ready("wd_next");
    set_req(0, 0, 26'h0, 32'h0);
    tick();
`ifdef MEM_ACCESS_STATS_EN
    check("stats_rd_count", rd_count, 2);
    check("stats_wr_count", wr_count, 0);
`endif

    repeat (4) tick();
    check("sb_acc_empty", exp_acc_q.size(), 0);
    check("sb_done_empty", exp_done_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
